// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debounce block.
// State encoding for the debounce FSM plus default sizing constants.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF  = 4;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous bit into clk.
// Reset clears the whole chain so the first sample after release is 0.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronize, debounce and edge-detect a raw 1-bit input.
// Define DEBOUNCE_GLITCH_CNT_EN to add the glitch_cnt port and counter.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  parameter int GLITCH_W    = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic out_level,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in_raw),
    .q  (w_s)
  );

  // cnt tracks agreeing samples of a candidate; it stops at CNT_LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        S_LO: begin
          if (w_s) begin
            if (DEB_CYCLES == 1) begin
              r_state <= S_HI;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WAIT_HI;
              r_cnt   <= CNT_ONE;
            end
          end
        end
        S_WAIT_HI: begin
          if (!w_s) begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_HI;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!w_s) begin
            if (DEB_CYCLES == 1) begin
              r_state <= S_LO;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WAIT_LO;
              r_cnt   <= CNT_ONE;
            end
          end
        end
        S_WAIT_LO: begin
          if (w_s) begin
            r_state <= S_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_LO;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign out_level = r_level;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign busy      = (r_state == S_WAIT_HI) ||
                     (r_state == S_WAIT_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                w_glitch;
  logic [GLITCH_W-1:0] r_glitch;

  // a wait state falling back to its stable state is a rejected glitch
  assign w_glitch = ((r_state == S_WAIT_HI) && !w_s) ||
                    ((r_state == S_WAIT_LO) &&  w_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= '0;
    end else if (w_glitch && (r_glitch != '1)) begin
      r_glitch <= r_glitch + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed steps plus random input bursts.
// Two instances: defaults, and SYNC_STAGES=3 / DEB_CYCLES=1.
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_raw = 1'b1;

  logic lvl1, rise1, fall1, busy1;
  logic lvl2, rise2, fall2, busy2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gl1, gl2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  input_debounce #(
    .SYNC_STAGES(2),
    .DEB_CYCLES (4)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (in_raw),
    .out_level(lvl1),
    .rise     (rise1),
    .fall     (fall1),
    .busy     (busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gl1)
`endif
  );

  input_debounce #(
    .SYNC_STAGES(3),
    .DEB_CYCLES (1)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (in_raw),
    .out_level(lvl2),
    .rise     (rise2),
    .fall     (fall2),
    .busy     (busy2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gl2)
`endif
  );

  // rawp: raw samples of past edges (bit 0 newest)
  // sh: samples seen past the synchronizer (bit 0 newest)
  typedef struct packed {
    logic [7:0] rawp;
    logic [7:0] sh;
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch;
  } mdl_t;

  mdl_t m1 = '0;
  mdl_t m2 = '0;

  // Level flips once the last deb synchronized samples all disagree.
  function automatic mdl_t mstep(mdl_t mi, logic r, logic in,
                                 int sync, int deb);
    mdl_t m;
    logic s, prev, diff;
    m = mi;
    if (r) return '0;
    s = m.rawp[sync-1];
    prev = m.sh[0];
    m.rawp = {m.rawp[6:0], in};
    m.sh = {m.sh[6:0], s};
    diff = 1'b1;
    for (int i = 0; i < deb; i++)
      if (m.sh[i] == m.level) diff = 1'b0;
    m.rise = 1'b0;
    m.fall = 1'b0;
    if (diff) begin
      m.level = ~m.level;
      m.rise = m.level;
      m.fall = ~m.level;
    end else if (s == m.level && prev != m.level &&
                 m.glitch != 8'hff) begin
      m.glitch = m.glitch + 8'd1;
    end
    m.busy = (s != m.level);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, rst, in_raw, 2, 4);
    m2 = mstep(m2, rst, in_raw, 3, 1);
    @(negedge clk);
    chk("d1_level", 32'(lvl1), 32'(m1.level));
    chk("d1_rise", 32'(rise1), 32'(m1.rise));
    chk("d1_fall", 32'(fall1), 32'(m1.fall));
    chk("d1_busy", 32'(busy1), 32'(m1.busy));
    chk("d2_level", 32'(lvl2), 32'(m2.level));
    chk("d2_rise", 32'(rise2), 32'(m2.rise));
    chk("d2_fall", 32'(fall2), 32'(m2.fall));
    chk("d2_busy", 32'(busy2), 32'(m2.busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("d1_glitch", 32'(gl1), 32'(m1.glitch));
    chk("d2_glitch", 32'(gl2), 32'(m2.glitch));
`endif
  endtask

  initial begin
    int v, len;

    // held high through reset
    rst = 1'b1;
    in_raw = 1'b1;
    repeat (3) tick();
    chk("t1_rst_level", 32'(lvl1), 32'd0);
    chk("t1_rst_busy", 32'(busy1), 32'd0);
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk("t1_rise", 32'(rise1), 32'(e == 5));
      chk("t1_level", 32'(lvl1), 32'(e >= 5));
    end
    repeat (5) tick();

    // clean 1->0 then 0->1 steps
    for (int k = 0; k < 2; k++) begin
      in_raw = (k == 1);
      for (int e = 0; e < 20; e++) begin
        tick();
        if (e <= 6) begin
          chk("t2_busy", 32'(busy1), 32'(e >= 2 && e <= 4));
          chk("t2_pulse", 32'(k ? rise1 : fall1), 32'(e == 5));
          chk("t2_d2_pulse", 32'(k ? rise2 : fall2),
              32'(e == 3));
          chk("t2_d2_level", 32'(lvl2),
              32'(e >= 3 ? k : 1 - k));
        end
      end
    end
    in_raw = 1'b0;
    repeat (12) tick();

    // 3-cycle glitch is rejected
    in_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 2) in_raw = 1'b0;
      chk("t3_rise", 32'(rise1), 32'd0);
      chk("t3_level", 32'(lvl1), 32'd0);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("t3_glitch", 32'(gl1), 32'd1);
`endif

    // exactly 4 samples qualifies
    in_raw = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (e == 3) in_raw = 1'b0;
      chk("t4_rise", 32'(rise1), 32'(e == 5));
      chk("t4_fall", 32'(fall1), 32'(e == 9));
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("t4_glitch", 32'(gl1), 32'd1);
`endif

    // reset during qualification
    in_raw = 1'b1;
    repeat (4) tick();
    chk("t5_busy_pre", 32'(busy1), 32'd1);
    rst = 1'b1;
    in_raw = 1'b0;
    tick();
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_level", 32'(lvl1), 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("t5_rise", 32'(rise1), 32'd0);
      chk("t5_fall", 32'(fall1), 32'd0);
    end

    // random bursts with occasional resets
    for (int n = 0; n < 1200; n++) begin
      v = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      in_raw = v[0];
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < len; c++) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
